// File: rtl/multiplier_arbiter_taint_pkg.sv
// Shared types and constants for the two-client, taint-tracked multiplier arbiter.
package multiplier_arbiter_taint_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] multiplier;
    logic             multiplier_t;
    logic [WIDTH-1:0] multiplicand;
    logic             multiplicand_t;
  } operands_t;

  typedef struct packed {
    logic [PROD_W-1:0] product;
    logic              product_t;
  } result_t;

  // Select the operand bundle of the requester identified by id.
  function automatic operands_t pick_operands(input logic id, input operands_t op0,
                                              input operands_t op1);
    return (id == REQ_ID1) ? op1 : op0;
  endfunction

endpackage

// File: rtl/multiplier_arbiter_taint_rr_arbiter2_taint.sv
// Two-way round-robin grant with pointer register and conservative grant taint.
module rr_arbiter2_taint
  import multiplier_arbiter_taint_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] valid_t,
  input  logic       accept,
  output logic       gnt_any_c,
  output logic       gnt_id_c,
  output logic       grant_t_c
);

  logic rr_q;
  logic rr_d;

  // Pointer only matters on contention; either valid bit can steer the choice.
  always_comb begin
    gnt_any_c = |valid;
    grant_t_c = |valid_t;
    if (&valid) begin
      gnt_id_c = rr_q;
    end else if (valid[1]) begin
      gnt_id_c = REQ_ID1;
    end else begin
      gnt_id_c = REQ_ID0;
    end
    rr_d = rr_q;
    if (accept && gnt_any_c) begin
      rr_d = ~gnt_id_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/multiplier_arbiter_taint.sv
// Shares one sequential multiplier core between two requesters, tracking taint on
// every control output and on the operand/product data paths.
module multiplier_arbiter_taint
  import multiplier_arbiter_taint_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_valid_t,
  output logic              req0_ready,
  output logic              req0_ready_t,
  input  logic [WIDTH-1:0]  req0_multiplier,
  input  logic              req0_multiplier_t,
  input  logic [WIDTH-1:0]  req0_multiplicand,
  input  logic              req0_multiplicand_t,

  input  logic              req1_valid,
  input  logic              req1_valid_t,
  output logic              req1_ready,
  output logic              req1_ready_t,
  input  logic [WIDTH-1:0]  req1_multiplier,
  input  logic              req1_multiplier_t,
  input  logic [WIDTH-1:0]  req1_multiplicand,
  input  logic              req1_multiplicand_t,

  output logic              resp0_valid,
  output logic              resp0_valid_t,
  input  logic              resp0_ready,
  input  logic              resp0_ready_t,
  output logic              resp1_valid,
  output logic              resp1_valid_t,
  input  logic              resp1_ready,
  input  logic              resp1_ready_t,
  output logic [PROD_W-1:0] resp_product,
  output logic              resp_product_t,

  output logic              mul_start,
  output logic              mul_start_t,
  output logic [WIDTH-1:0]  mul_multiplier,
  output logic              mul_multiplier_t,
  output logic [WIDTH-1:0]  mul_multiplicand,
  output logic              mul_multiplicand_t,
  input  logic [PROD_W-1:0] mul_product,
  input  logic              mul_product_t,
  input  logic              mul_done,
  input  logic              mul_done_t
);

  state_e    state_q, state_d;
  logic      state_t_q, state_t_d;
  logic      gid_q, gid_d;
  logic      grant_t_q, grant_t_d;
  operands_t ops_q, ops_d;
  result_t   res_q, res_d;

  logic      idle;
  logic      busy;
  logic      in_resp;
  logic      accept;
  logic      gnt_any;
  logic      gnt_id;
  logic      grant_t_c;
  logic      rsp_ready;
  logic      rsp_ready_t;
  operands_t req0_ops;
  operands_t req1_ops;

  assign req0_ops = '{multiplier:     req0_multiplier,
                      multiplier_t:   req0_multiplier_t,
                      multiplicand:   req0_multiplicand,
                      multiplicand_t: req0_multiplicand_t};
  assign req1_ops = '{multiplier:     req1_multiplier,
                      multiplier_t:   req1_multiplier_t,
                      multiplicand:   req1_multiplicand,
                      multiplicand_t: req1_multiplicand_t};

  // Ready is suppressed during reset so nothing is accepted on the reset edge.
  assign idle    = (state_q == ST_IDLE) && !rst;
  assign busy    = (state_q != ST_IDLE);
  assign in_resp = (state_q == ST_RESP);
  assign accept  = idle && gnt_any;

  rr_arbiter2_taint u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     ({req1_valid, req0_valid}),
    .valid_t   ({req1_valid_t, req0_valid_t}),
    .accept    (accept),
    .gnt_any_c (gnt_any),
    .gnt_id_c  (gnt_id),
    .grant_t_c (grant_t_c)
  );

  assign rsp_ready   = (gid_q == REQ_ID1) ? resp1_ready   : resp0_ready;
  assign rsp_ready_t = (gid_q == REQ_ID1) ? resp1_ready_t : resp0_ready_t;

  // Next-state, latches and sticky control taint.
  always_comb begin
    state_d   = state_q;
    state_t_d = state_t_q;
    gid_d     = gid_q;
    grant_t_d = grant_t_q;
    ops_d     = ops_q;
    res_d     = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_ISSUE;
          gid_d     = gnt_id;
          grant_t_d = grant_t_c;
          state_t_d = grant_t_c;
          ops_d     = pick_operands(gnt_id, req0_ops, req1_ops);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_t_d = state_t_q | mul_done_t;
        if (mul_done) begin
          res_d   = '{product: mul_product, product_t: mul_product_t};
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_t_d = state_t_q | rsp_ready_t;
        if (rsp_ready) begin
          state_d   = ST_IDLE;
          // A clean exit clears the sticky taint; a tainted one keeps it set.
          state_t_d = rsp_ready_t;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      state_t_q <= 1'b0;
      gid_q     <= REQ_ID0;
      grant_t_q <= 1'b0;
      ops_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      state_t_q <= state_t_d;
      gid_q     <= gid_d;
      grant_t_q <= grant_t_d;
      ops_q     <= ops_d;
      res_q     <= res_d;
    end
  end

  assign req0_ready   = accept && (gnt_id == REQ_ID0);
  assign req1_ready   = accept && (gnt_id == REQ_ID1);
  assign req0_ready_t = idle && grant_t_c;
  assign req1_ready_t = idle && grant_t_c;

  assign mul_start   = (state_q == ST_ISSUE);
  assign mul_start_t = state_t_q;

  // Core operands are held from ISSUE through RESP and forced to zero in IDLE.
  assign mul_multiplier     = busy ? ops_q.multiplier   : '0;
  assign mul_multiplicand   = busy ? ops_q.multiplicand : '0;
  assign mul_multiplier_t   = busy && (ops_q.multiplier_t   || grant_t_q);
  assign mul_multiplicand_t = busy && (ops_q.multiplicand_t || grant_t_q);

  assign resp0_valid    = in_resp && (gid_q == REQ_ID0);
  assign resp1_valid    = in_resp && (gid_q == REQ_ID1);
  assign resp0_valid_t  = state_t_q;
  assign resp1_valid_t  = state_t_q;
  assign resp_product   = in_resp ? res_q.product : '0;
  assign resp_product_t = in_resp && (res_q.product_t || grant_t_q);

endmodule

// File: tb/tb_multiplier_arbiter_taint.sv
// Self-checking bench: a small fixed-latency taint-tracked core model plus
// a transaction-level reference for grants, products and taints.
module tb_multiplier_arbiter_taint;

  localparam int unsigned W        = 4;
  localparam int unsigned PW       = 8;
  localparam int unsigned CORE_LAT = 3;
  localparam int unsigned TIMEOUT  = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req0_valid_t, req0_ready, req0_ready_t;
  logic [W-1:0]  req0_multiplier, req0_multiplicand;
  logic          req0_multiplier_t, req0_multiplicand_t;
  logic          req1_valid, req1_valid_t, req1_ready, req1_ready_t;
  logic [W-1:0]  req1_multiplier, req1_multiplicand;
  logic          req1_multiplier_t, req1_multiplicand_t;
  logic          resp0_valid, resp0_valid_t, resp0_ready, resp0_ready_t;
  logic          resp1_valid, resp1_valid_t, resp1_ready, resp1_ready_t;
  logic [PW-1:0] resp_product;
  logic          resp_product_t;
  logic          mul_start, mul_start_t;
  logic [W-1:0]  mul_multiplier, mul_multiplicand;
  logic          mul_multiplier_t, mul_multiplicand_t;
  logic [PW-1:0] mul_product;
  logic          mul_product_t, mul_done, mul_done_t;

  int unsigned cyc = 0;
  int unsigned start_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  bit          model_rr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mul_start === 1'b1) start_cnt <= start_cnt + 1;

  // Core model: product appears CORE_LAT cycles after the start cycle.
  logic          core_busy;
  int unsigned   core_cnt;
  logic [PW-1:0] core_p;
  logic          core_pt, core_dt;
  always @(posedge clk) begin
    if (rst) begin
      core_busy <= 1'b0; core_cnt <= 0; core_p <= '0; core_pt <= 1'b0; core_dt <= 1'b0;
    end else if (mul_start) begin
      core_busy <= 1'b1;
      core_cnt  <= CORE_LAT - 1;
      core_p    <= PW'(mul_multiplier) * PW'(mul_multiplicand);
      core_pt   <= mul_multiplier_t | mul_multiplicand_t | mul_start_t;
      core_dt   <= mul_start_t;
    end else if (core_busy) begin
      if (core_cnt == 0) core_busy <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end
  end
  assign mul_done      = core_busy && (core_cnt == 0);
  assign mul_done_t    = mul_done && core_dt;
  assign mul_product   = core_p;
  assign mul_product_t = core_pt;

  multiplier_arbiter_taint dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_valid_t(req0_valid_t),
    .req0_ready(req0_ready), .req0_ready_t(req0_ready_t),
    .req0_multiplier(req0_multiplier), .req0_multiplier_t(req0_multiplier_t),
    .req0_multiplicand(req0_multiplicand), .req0_multiplicand_t(req0_multiplicand_t),
    .req1_valid(req1_valid), .req1_valid_t(req1_valid_t),
    .req1_ready(req1_ready), .req1_ready_t(req1_ready_t),
    .req1_multiplier(req1_multiplier), .req1_multiplier_t(req1_multiplier_t),
    .req1_multiplicand(req1_multiplicand), .req1_multiplicand_t(req1_multiplicand_t),
    .resp0_valid(resp0_valid), .resp0_valid_t(resp0_valid_t),
    .resp0_ready(resp0_ready), .resp0_ready_t(resp0_ready_t),
    .resp1_valid(resp1_valid), .resp1_valid_t(resp1_valid_t),
    .resp1_ready(resp1_ready), .resp1_ready_t(resp1_ready_t),
    .resp_product(resp_product), .resp_product_t(resp_product_t),
    .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
    .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t)
  );

  function automatic logic [28:0] outs();
    return {req0_ready, req0_ready_t, req1_ready, req1_ready_t,
            resp0_valid, resp0_valid_t, resp1_valid, resp1_valid_t,
            resp_product, resp_product_t, mul_start, mul_start_t,
            mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_valid_t = 0; req0_multiplier = '0; req0_multiplier_t = 0;
    req0_multiplicand = '0; req0_multiplicand_t = 0;
    req1_valid = 0; req1_valid_t = 0; req1_multiplier = '0; req1_multiplier_t = 0;
    req1_multiplicand = '0; req1_multiplicand_t = 0;
    resp0_ready = 0; resp0_ready_t = 0; resp1_ready = 0; resp1_ready_t = 0;
  endtask

  task automatic drive_req(input bit side, input logic [W-1:0] a, input bit at,
                           input logic [W-1:0] b, input bit bt, input bit vt);
    if (side) begin
      req1_valid = 1; req1_valid_t = vt; req1_multiplier = a; req1_multiplier_t = at;
      req1_multiplicand = b; req1_multiplicand_t = bt;
    end else begin
      req0_valid = 1; req0_valid_t = vt; req0_multiplier = a; req0_multiplier_t = at;
      req0_multiplicand = b; req0_multiplicand_t = bt;
    end
  endtask

  task automatic drop_req(input bit side);
    if (side) begin
      req1_valid = 0; req1_valid_t = 0; req1_multiplier = '0; req1_multiplier_t = 0;
      req1_multiplicand = '0; req1_multiplicand_t = 0;
    end else begin
      req0_valid = 0; req0_valid_t = 0; req0_multiplier = '0; req0_multiplier_t = 0;
      req0_multiplicand = '0; req0_multiplicand_t = 0;
    end
  endtask

  task automatic wait_resp(input bit side, output int unsigned c, output bit ok);
    ok = 0;
    c  = 0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      if (!ok) begin
        @(negedge clk);
        if ((side ? resp1_valid : resp0_valid) === 1'b1) begin
          ok = 1;
          c  = cyc;
        end
      end
    end
  endtask

  task automatic consume(input bit side, input bit rt);
    if (side) begin resp1_ready = 1; resp1_ready_t = rt; end
    else begin resp0_ready = 1; resp0_ready_t = rt; end
    step();
    resp0_ready = 0; resp0_ready_t = 0; resp1_ready = 0; resp1_ready_t = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (outs() !== 29'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", outs());
    end
    drive_req(0, 4'd1, 0, 4'd1, 0, 1);
    drive_req(1, 4'd1, 0, 4'd1, 0, 1);
    #1;
    checks++;
    if ({req0_ready, req1_ready, req0_ready_t, req1_ready_t} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_no_accept: got %b want 0000", {req0_ready, req1_ready, req0_ready_t, req1_ready_t});
    end
    idle_inputs();
    step();
    rst = 0;
    model_rr = 0;
  endtask

  task automatic test_single();
    int unsigned c_acc, c_rsp, s0;
    bit ok;
    step();
    s0 = start_cnt;
    drive_req(0, 4'd3, 0, 4'd5, 0, 0);
    @(negedge clk);
    c_acc = cyc;
    checks++;
    if ({req0_ready, req0_ready_t, req1_ready} !== 3'b100) begin
      errors++; $display("FAIL single_ready: got %b want 100", {req0_ready, req0_ready_t, req1_ready});
    end
    step();
    drop_req(0);
    model_rr = 1;
    wait_resp(0, c_rsp, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: no resp0_valid within %0d cycles", TIMEOUT); end
    checks++;
    if (c_rsp - c_acc !== CORE_LAT + 2) begin
      errors++; $display("FAIL single_latency: got %0d want %0d", c_rsp - c_acc, CORE_LAT + 2);
    end
    checks++;
    if (resp_product !== 8'd15) begin
      errors++; $display("FAIL single_product: got %0d want 15", resp_product);
    end
    checks++;
    if ({resp0_valid_t, resp_product_t, mul_start_t, mul_multiplier_t, mul_multiplicand_t} !== 5'b0) begin
      errors++; $display("FAIL single_taints: got %b want 00000",
                         {resp0_valid_t, resp_product_t, mul_start_t, mul_multiplier_t, mul_multiplicand_t});
    end
    #1;
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++; $display("FAIL single_start_pulses: got %0d want 1", start_cnt - s0);
    end
    consume(0, 0);
    @(negedge clk);
    checks++;
    if ({resp0_valid, mul_multiplier, mul_multiplicand} !== 9'd0) begin
      errors++; $display("FAIL single_release: got %h want 0", {resp0_valid, mul_multiplier, mul_multiplicand});
    end
  endtask

  task automatic test_contention();
    int unsigned c;
    bit ok;
    step();
    rst = 1;
    step();
    rst = 0;
    model_rr = 0;
    step();
    drive_req(0, 4'd9, 0, 4'd7, 0, 0);
    drive_req(1, 4'd2, 0, 4'd6, 0, 0);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== (model_rr ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL contention_first_grant: got %b want 01", {req1_ready, req0_ready});
    end
    step();
    drop_req(0);
    model_rr = 1;
    wait_resp(0, c, ok);
    checks++;
    if (!ok || resp_product !== 8'd63 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL contention_resp0: ok=%0b product=%0d req1_ready=%b want 1/63/0", ok, resp_product, req1_ready);
    end
    consume(0, 0);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL contention_second_grant: got %b want 10", {req1_ready, req0_ready});
    end
    step();
    drop_req(1);
    model_rr = 0;
    wait_resp(1, c, ok);
    checks++;
    if (!ok || resp_product !== 8'd12) begin
      errors++; $display("FAIL contention_resp1: ok=%0b product=%0d want 1/12", ok, resp_product);
    end
    consume(1, 0);
  endtask

  task automatic test_operand_taint();
    int unsigned c;
    bit ok;
    step();
    drive_req(1, 4'd4, 0, 4'd4, 1, 0);
    @(negedge clk);
    checks++;
    if ({req1_ready, req1_ready_t} !== 2'b10) begin
      errors++; $display("FAIL optaint_ready: got %b want 10", {req1_ready, req1_ready_t});
    end
    step();
    drop_req(1);
    model_rr = 0;
    wait_resp(1, c, ok);
    checks++;
    if (!ok || resp_product !== 8'd16 || resp_product_t !== 1'b1 || resp1_valid_t !== 1'b0) begin
      errors++; $display("FAIL optaint_resp: ok=%0b product=%0d product_t=%b valid_t=%b want 1/16/1/0",
                         ok, resp_product, resp_product_t, resp1_valid_t);
    end
    consume(1, 0);
  endtask

  task automatic test_control_taint();
    int unsigned c;
    bit ok;
    logic [W-1:0] a, b;
    a = W'($urandom_range(15));
    b = W'($urandom_range(15));
    step();
    drive_req(0, a, 0, b, 0, 1);
    @(negedge clk);
    checks++;
    if ({req0_ready, req0_ready_t} !== 2'b11) begin
      errors++; $display("FAIL ctaint_ready: got %b want 11", {req0_ready, req0_ready_t});
    end
    step();
    drop_req(0);
    model_rr = 1;
    @(negedge clk);
    checks++;
    if ({mul_start, mul_start_t, mul_multiplier_t, mul_multiplicand_t} !== 4'b1111) begin
      errors++; $display("FAIL ctaint_issue: got %b want 1111", {mul_start, mul_start_t, mul_multiplier_t, mul_multiplicand_t});
    end
    wait_resp(0, c, ok);
    checks++;
    if (!ok || resp_product !== PW'(a) * PW'(b) || {resp0_valid_t, resp_product_t} !== 2'b11) begin
      errors++; $display("FAIL ctaint_resp: ok=%0b product=%0d taints=%b want 1/%0d/11",
                         ok, resp_product, {resp0_valid_t, resp_product_t}, PW'(a) * PW'(b));
    end
    consume(0, 0);
    @(negedge clk);
    checks++;
    if ({mul_start_t, resp0_valid_t, resp1_valid_t} !== 3'b000) begin
      errors++; $display("FAIL ctaint_clear: got %b want 000", {mul_start_t, resp0_valid_t, resp1_valid_t});
    end
  endtask

  task automatic test_backpressure();
    int unsigned c;
    bit ok;
    int bad;
    logic [PW-1:0] held;
    step();
    drive_req(0, 4'd6, 0, 4'd11, 0, 0);
    step();
    drop_req(0);
    model_rr = 1;
    drive_req(1, 4'd13, 0, 4'd2, 0, 0);
    wait_resp(0, c, ok);
    held = resp_product;
    checks++;
    if (!ok || held !== 8'd66) begin
      errors++; $display("FAIL bp_first: ok=%0b product=%0d want 1/66", ok, held);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bad = 0;
      if (resp0_valid !== 1'b1 || resp_product !== held || req1_ready !== 1'b0) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b product=%0d req1_ready=%b want 1/%0d/0",
                           i, resp0_valid, resp_product, req1_ready, held);
      end
    end
    consume(0, 0);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_next_grant: got %b want 1", req1_ready);
    end
    step();
    drop_req(1);
    model_rr = 0;
    wait_resp(1, c, ok);
    checks++;
    if (!ok || resp_product !== 8'd26) begin
      errors++; $display("FAIL bp_second: ok=%0b product=%0d want 1/26", ok, resp_product);
    end
    consume(1, 0);
  endtask

  task automatic test_reset_mid_wait();
    int unsigned c;
    bit ok;
    bit seen;
    step();
    drive_req(0, 4'd7, 0, 4'd7, 0, 0);
    step();
    drop_req(0);
    model_rr = 1;
    step();
    rst = 1;
    step();
    @(negedge clk);
    checks++;
    if (outs() !== 29'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h want 0", outs());
    end
    step();
    rst = 0;
    model_rr = 0;
    seen = 0;
    for (int i = 0; i < int'(CORE_LAT) + 4; i++) begin
      @(negedge clk);
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midreset_no_resp: got a response want none");
    end
    step();
    drive_req(0, 4'd5, 0, 4'd3, 0, 0);
    drive_req(1, 4'd8, 0, 4'd8, 0, 0);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL midreset_rr: got %b want 01", {req1_ready, req0_ready});
    end
    step();
    drop_req(0);
    drop_req(1);
    model_rr = 1;
    wait_resp(0, c, ok);
    checks++;
    if (!ok || resp_product !== 8'd15) begin
      errors++; $display("FAIL midreset_after: ok=%0b product=%0d want 1/15", ok, resp_product);
    end
    consume(0, 0);
  endtask

  task automatic test_random();
    int unsigned c_acc, c_rsp;
    bit ok, v0, v1, win, gt, vt0, vt1, at0, bt0, at1, bt1, rt, exp_pt;
    logic [W-1:0] a0, b0, a1, b1;
    logic [PW-1:0] exp_p;
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(2))
        0: begin v0 = 1; v1 = 0; end
        1: begin v0 = 0; v1 = 1; end
        default: begin v0 = 1; v1 = 1; end
      endcase
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      at0 = ($urandom_range(3) == 0); bt0 = ($urandom_range(3) == 0);
      at1 = ($urandom_range(3) == 0); bt1 = ($urandom_range(3) == 0);
      vt0 = v0 && ($urandom_range(3) == 0);
      vt1 = v1 && ($urandom_range(3) == 0);
      rt  = ($urandom_range(3) == 0);
      win = (v0 && v1) ? model_rr : v1;
      gt  = vt0 | vt1;
      exp_p  = win ? PW'(a1) * PW'(b1) : PW'(a0) * PW'(b0);
      exp_pt = (win ? (at1 | bt1) : (at0 | bt0)) | gt;
      step();
      if (v0) drive_req(0, a0, at0, b0, bt0, vt0);
      if (v1) drive_req(1, a1, at1, b1, bt1, vt1);
      @(negedge clk);
      c_acc = cyc;
      checks++;
      if ({req1_ready, req0_ready, req0_ready_t, req1_ready_t} !== {win, ~win, gt, gt}) begin
        errors++; $display("FAIL rand_grant[%0d]: got %b want %b", it,
                           {req1_ready, req0_ready, req0_ready_t, req1_ready_t}, {win, ~win, gt, gt});
      end
      step();
      drop_req(0);
      drop_req(1);
      model_rr = ~win;
      wait_resp(win, c_rsp, ok);
      checks++;
      if (!ok || c_rsp - c_acc !== CORE_LAT + 2) begin
        errors++; $display("FAIL rand_latency[%0d]: ok=%0b latency=%0d want %0d", it, ok, c_rsp - c_acc, CORE_LAT + 2);
      end
      checks++;
      if (resp_product !== exp_p || resp_product_t !== exp_pt ||
          (win ? resp1_valid_t : resp0_valid_t) !== gt) begin
        errors++; $display("FAIL rand_resp[%0d]: product=%0d product_t=%b valid_t=%b want %0d/%b/%b", it,
                           resp_product, resp_product_t, win ? resp1_valid_t : resp0_valid_t, exp_p, exp_pt, gt);
      end
      consume(win, rt);
      @(negedge clk);
      checks++;
      if ({resp0_valid, resp1_valid, mul_start_t} !== {1'b0, 1'b0, rt}) begin
        errors++; $display("FAIL rand_exit[%0d]: got %b want %b", it,
                           {resp0_valid, resp1_valid, mul_start_t}, {1'b0, 1'b0, rt});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_operand_taint();
    test_control_taint();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
